// File: rtl/studio2_ram_arbiter.sv
// studio2_ram_arbiter
//
// Shares the single-port system block RAM between the cartridge download
// loader, the CDP1861 video DMA and the CDP1802 CPU. Each access takes three
// cycles: IDLE (arbitrate and latch the winner's request), ISSUE (drive the RAM
// port) and DONE (return read data and pulse the winner's ack).
//
// Priority is download > DMA > CPU. The CPU counts consecutive lost
// arbitrations. Once that count reaches CPU_MAX_WAIT, the CPU outranks DMA for
// one grant. Download still outranks the CPU in that case.
//
// Optional build macro: STUDIO2_ARB_WRPROT_EN
//   When defined, CPU writes below WP_LIMIT still go through the normal
//   handshake, but they never reach the RAM. Both mem_cs and mem_we stay low.
//
// Ports
//   clk, reset_n                    system clock, async active-low reset
//   dl_req/dl_addr/dl_wdata/dl_ack  download write port
//   dma_req/dma_addr/dma_ack        video DMA read port
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata/cpu_ack               CPU read/write port
//   rdata                           read data for the acked requester
//   mem_cs/mem_we/mem_addr/
//   mem_din/mem_dout                RAM port (1-cycle synchronous read)
//   owner                           0 none, 1 dl, 2 dma, 3 cpu
//   busy                            access in flight (ISSUE or DONE)
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its address/data/we
// ISSUE | RAM chip select asserted with the latched request
// DONE  | RAM read data valid; ack the owner; capture rdata on reads

module studio2_ram_arbiter #(
    parameter int AW           = 12,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_wdata,
    output logic          dl_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic [1:0]    owner,
    output logic          busy
);

    localparam int WW = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DL   = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic            we_q, we_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            cpu_promote;
    logic            drop_q;

`ifdef STUDIO2_ARB_WRPROT_EN
    localparam logic [AW-1:0] WP_LIMIT = AW'('h800);
    logic drop_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef STUDIO2_ARB_WRPROT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    assign drop_q = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = we_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        cpu_promote = 1'b0;
`ifdef STUDIO2_ARB_WRPROT_EN
        drop_d      = drop_q;
`endif

        case (state_q)
            IDLE: begin
                owner_d     = OWN_NONE;
                cpu_promote = (wait_q == WAIT_MAX) && cpu_req && !dl_req;
                if (dl_req) begin
                    owner_d = OWN_DL;
                    addr_d  = dl_addr;
                    din_d   = dl_wdata;
                    we_d    = 1'b1;
                end else if (dma_req && !cpu_promote) begin
                    owner_d = OWN_DMA;
                    addr_d  = dma_addr;
                    din_d   = 8'h00;
                    we_d    = 1'b0;
                end else if (cpu_req) begin
                    owner_d = OWN_CPU;
                    addr_d  = cpu_addr;
                    din_d   = cpu_wdata;
                    we_d    = cpu_we;
                end

`ifdef STUDIO2_ARB_WRPROT_EN
                drop_d = (owner_d == OWN_CPU) && cpu_we && (cpu_addr < WP_LIMIT);
`endif

                if (owner_d != OWN_NONE) begin
                    state_d = ISSUE;
                end

                // Losses only count while the CPU is actually asking.
                if (!cpu_req || owner_d == OWN_CPU) begin
                    wait_d = '0;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WW'(1);
                end
            end

            ISSUE: begin
                state_d = DONE;
            end

            DONE: begin
                if (!we_q) begin
                    rdata_d = mem_dout;
                end
                owner_d = OWN_NONE;
                state_d = IDLE;
            end

            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    assign mem_cs   = (state_q == ISSUE) && !drop_q;
    assign mem_we   = (state_q == ISSUE) && we_q && !drop_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);

    assign dl_ack   = (state_q == DONE) && (owner_q == OWN_DL);
    assign dma_ack  = (state_q == DONE) && (owner_q == OWN_DMA);
    assign cpu_ack  = (state_q == DONE) && (owner_q == OWN_CPU);

    // The RAM output is valid only during DONE. It is forwarded there so that
    // read data lines up with the ack. The same value is held in rdata_q
    // until the next read completes.
    assign rdata    = (state_q == DONE && !we_q) ? mem_dout : rdata_q;

endmodule
